spi_frame_ctrl: RTL and testbench

Frame-level controller between the SPI byte receiver and the RGBW PWM datapath. Consumes the receiver's `rdy`/`data` byte stream, decodes each chip-select frame (header byte plus data bytes), writes payload into shadow registers with address auto-increment, and atomically commits the shadow set to the active colour/intensity/mode registers when the frame ends cleanly. Malformed frames are dropped whole; active registers never show a partial update.

---
 rtl/rgbw_regs_pkg.sv | 51 +++++
 rtl/sync_2ff.sv | 24 ++
 rtl/spi_frame_ctrl.sv | 150 +++++++++++++++
 tb/tb_spi_frame_ctrl.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/rgbw_regs_pkg.sv
// rgbw_regs_pkg: shared definitions for the RGBW frame controller.
//   - header opcodes and register-map addresses
//   - default (reset) register values
//   - frame FSM state enumeration
package rgbw_regs_pkg;

  localparam int NUM_REGS = 6;

  // Header opcodes (header[7:4])
  localparam logic [3:0] OP_WRITE    = 4'h1;
  localparam logic [3:0] OP_DEFAULTS = 4'h3;

  // Register map indices
  localparam int REG_RED       = 0;
  localparam int REG_GREEN     = 1;
  localparam int REG_BLUE      = 2;
  localparam int REG_WHITE     = 3;
  localparam int REG_INTENSITY = 4;
  localparam int REG_MODE      = 5;

  // Highest valid address, in header-address width
  localparam logic [3:0] ADDR_MAX = 4'd5;

  localparam logic [7:0] DEF_COLOUR    = 8'h00;
  localparam logic [7:0] DEF_MODE      = 8'h00;
  localparam logic [7:0] DEF_INTENSITY = 8'hFF;

  typedef logic [NUM_REGS-1:0][7:0] regs_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HEADER,
    ST_DATA,
    ST_DISCARD,
    ST_COMMIT
  } state_t;

  // Full default register set; intensity default is a top-level parameter.
  function automatic regs_t reg_defaults(input logic [7:0] intensity_def);
    regs_t r;
    r                = '0;
    r[REG_RED]       = DEF_COLOUR;
    r[REG_GREEN]     = DEF_COLOUR;
    r[REG_BLUE]      = DEF_COLOUR;
    r[REG_WHITE]     = DEF_COLOUR;
    r[REG_INTENSITY] = intensity_def;
    r[REG_MODE]      = DEF_MODE;
    return r;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: single-bit synchroniser of parameterised depth.
//   clk   : destination clock
//   rst_n : async active-low reset, chain resets to 1 (deselected cs)
//   d     : asynchronous input
//   q     : synchronised output, STAGES cycles of latency
module sync_2ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sync <= '1;
    else        r_sync <= {r_sync[STAGES-2:0], d};
  end

  assign q = r_sync[STAGES-1];

endmodule

// File: rtl/spi_frame_ctrl.sv
// spi_frame_ctrl: decodes chip-select framed byte streams from the SPI
// receiver into shadow registers and commits them atomically to the active
// RGBW/intensity/mode registers at a clean end of frame.
//   clk       : system clock (same as SPI receiver)
//   reset     : async active-low reset
//   cs        : raw active-low chip select (asynchronous)
//   rdy/data  : receiver byte strobe (level, edge-detected here) and byte
//   red..mode : active register outputs
//   update    : one-cycle pulse when active registers change
//   frame_err : one-cycle pulse when a frame is discarded
import rgbw_regs_pkg::*;

module spi_frame_ctrl #(
  parameter int         CS_SYNC_STAGES = 2,
  parameter logic [7:0] INTENSITY_RST  = 8'hFF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cs,
  input  logic       rdy,
  input  logic [7:0] data,
  output logic [7:0] red,
  output logic [7:0] green,
  output logic [7:0] blue,
  output logic [7:0] white,
  output logic [7:0] intensity,
  output logic [7:0] mode,
  output logic       update,
  output logic       frame_err
);

  logic       w_cs_s;
  logic       w_acc;
  logic [2:0] w_idx;

  state_t     r_state;
  regs_t      r_active;
  regs_t      r_shadow;
  logic [3:0] r_addr;
  logic       r_rdy_q;
  logic       r_dirty;
  logic       r_err;
  logic       r_ign;     // DEFAULTS frame: trailing bytes are dropped silently

  sync_2ff #(.STAGES(CS_SYNC_STAGES)) u_cs_sync (
    .clk   (clk),
    .rst_n (reset),
    .d     (cs),
    .q     (w_cs_s)
  );

  // One byte per rising edge of rdy, however long it is held.
  assign w_acc = rdy & ~r_rdy_q;
  assign w_idx = r_addr[2:0];

  assign red       = r_active[REG_RED];
  assign green     = r_active[REG_GREEN];
  assign blue      = r_active[REG_BLUE];
  assign white     = r_active[REG_WHITE];
  assign intensity = r_active[REG_INTENSITY];
  assign mode      = r_active[REG_MODE];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_active  <= reg_defaults(INTENSITY_RST);
      r_shadow  <= reg_defaults(INTENSITY_RST);
      r_addr    <= '0;
      r_rdy_q   <= 1'b0;
      r_dirty   <= 1'b0;
      r_err     <= 1'b0;
      r_ign     <= 1'b0;
      update    <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      r_rdy_q   <= rdy;
      update    <= 1'b0;
      frame_err <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (!w_cs_s) begin
            r_state  <= ST_HEADER;
            r_shadow <= r_active;
            r_dirty  <= 1'b0;
            r_err    <= 1'b0;
          end
        end

        ST_HEADER: begin
          if (w_acc) begin
            r_addr <= data[3:0];
            if (data[7:4] == OP_WRITE && data[3:0] <= ADDR_MAX) begin
              r_ign   <= 1'b0;
              r_state <= ST_DATA;
            end else if (data[7:4] == OP_DEFAULTS) begin
              r_shadow <= reg_defaults(INTENSITY_RST);
              r_dirty  <= 1'b1;
              r_ign    <= 1'b1;
              r_state  <= ST_DATA;
            end else begin
              r_err   <= 1'b1;
              r_state <= ST_DISCARD;
            end
          end
          // A byte landing together with the cs rise is still processed above.
          if (w_cs_s) r_state <= ST_COMMIT;
        end

        ST_DATA: begin
          if (w_acc && !r_ign) begin
            if (r_addr <= ADDR_MAX) begin
              r_shadow[w_idx] <= data;
              r_dirty         <= 1'b1;
              r_addr          <= r_addr + 4'd1;
            end else begin
              r_err   <= 1'b1;
              r_state <= ST_DISCARD;
            end
          end
          if (w_cs_s) r_state <= ST_COMMIT;
        end

        ST_DISCARD: begin
          if (w_cs_s) r_state <= ST_COMMIT;
        end

        ST_COMMIT: begin
          if (r_dirty && !r_err) begin
            r_active <= r_shadow;
            update   <= 1'b1;
          end
          if (r_err) frame_err <= 1'b1;
          r_dirty <= 1'b0;
          r_err   <= 1'b0;
          if (!w_cs_s) begin
            // Back-to-back frame: shadow must track what active becomes.
            r_state <= ST_HEADER;
            if (r_err || !r_dirty) r_shadow <= r_active;
          end else begin
            r_state <= ST_IDLE;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_frame_ctrl.sv
// Self-checking bench for spi_frame_ctrl: directed frames from the test plan
// followed by randomized frames, compared against a frame-level model.
module tb_spi_frame_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       cs = 1'b1;
  logic       rdy = 1'b0;
  logic [7:0] data = 8'h00;
  logic [7:0] red, green, blue, white, intensity, mode;
  logic       update, frame_err;

  int n_cmp = 0;
  int n_bad = 0;
  int cnt_upd = 0;
  int cnt_err = 0;

  // model: active register values and expected pulse totals
  logic [7:0] m_act [6];
  int m_upd = 0;
  int m_err = 0;

  spi_frame_ctrl #(.CS_SYNC_STAGES(2), .INTENSITY_RST(8'hFF)) dut (
    .clk       (clk),
    .reset     (reset),
    .cs        (cs),
    .rdy       (rdy),
    .data      (data),
    .red       (red),
    .green     (green),
    .blue      (blue),
    .white     (white),
    .intensity (intensity),
    .mode      (mode),
    .update    (update),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (update)    cnt_upd <= cnt_upd + 1;
    if (frame_err) cnt_err <= cnt_err + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_defaults();
    m_act = '{8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h00};
  endtask

  // Frame-level behaviour: header decides the kind, data fills from start address.
  task automatic model_frame(input logic [7:0] fb[$]);
    logic [7:0] sh [6];
    logic [7:0] hdr;
    int  a;
    bit  err, dirty;
    err = 0; dirty = 0; sh = m_act;
    if (fb.size() == 0) return;
    hdr = fb[0];
    a = int'(hdr[3:0]);
    if (hdr[7:4] == 4'h1) begin
      if (a > 5) err = 1;
      else
        for (int i = 1; i < fb.size(); i++) begin
          if (a > 5) begin err = 1; break; end
          sh[a] = fb[i]; a++; dirty = 1;
        end
    end else if (hdr[7:4] == 4'h3) begin
      sh = '{8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h00};
      dirty = 1;
    end else begin
      err = 1;
    end
    if (err) m_err++;
    else if (dirty) begin m_act = sh; m_upd++; end
  endtask

  task automatic push_byte(input logic [7:0] b, input int hold);
    data = b;
    rdy  = 1'b1;
    repeat (hold) @(negedge clk);
    rdy  = 1'b0;
    data = 8'($urandom);
    repeat ($urandom_range(1, 3)) @(negedge clk);
  endtask

  // hold = 0 picks a random rdy high time per byte
  task automatic send_frame(input logic [7:0] fb[$], input int gap, input int hold);
    cs = 1'b0;
    repeat (4) @(negedge clk);
    foreach (fb[i]) push_byte(fb[i], (hold > 0) ? hold : int'($urandom_range(1, 3)));
    cs = 1'b1;
    repeat (gap) @(negedge clk);
    model_frame(fb);
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".red"},   {24'h0, red},       {24'h0, m_act[0]});
    chk({tag, ".green"}, {24'h0, green},     {24'h0, m_act[1]});
    chk({tag, ".blue"},  {24'h0, blue},      {24'h0, m_act[2]});
    chk({tag, ".white"}, {24'h0, white},     {24'h0, m_act[3]});
    chk({tag, ".inten"}, {24'h0, intensity}, {24'h0, m_act[4]});
    chk({tag, ".mode"},  {24'h0, mode},      {24'h0, m_act[5]});
    chk({tag, ".n_upd"}, cnt_upd,            m_upd);
    chk({tag, ".n_err"}, cnt_err,            m_err);
  endtask

  initial begin
    logic [7:0] fb[$];
    logic [7:0] hdr;
    int r, n;

    model_defaults();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check_state("reset");
    chk("reset.update",    {31'h0, update},    32'h0);
    chk("reset.frame_err", {31'h0, frame_err}, 32'h0);

    fb = '{8'h10, 8'h11, 8'h22, 8'h33, 8'h44}; send_frame(fb, 10, 0); check_state("wr_all");
    fb = '{8'h14, 8'h80, 8'h05};               send_frame(fb, 10, 0); check_state("mid_map");
    fb = '{8'h15, 8'h01, 8'h02};               send_frame(fb, 10, 0); check_state("overrun");
    fb = '{8'h70};                             send_frame(fb, 10, 0); check_state("bad_op");
    fb = {};                                   send_frame(fb, 10, 0); check_state("empty");
    fb = '{8'h10};                             send_frame(fb, 10, 0); check_state("hdr_only");
    fb = '{8'h30, 8'h99, 8'h77};               send_frame(fb, 10, 0); check_state("defaults");
    fb = '{8'h16};                             send_frame(fb, 10, 0); check_state("bad_addr");

    // back-to-back frames with a one-cycle cs gap
    fb = '{8'h12, 8'h5A};                      send_frame(fb, 1, 0);
    fb = '{8'h13, 8'h6B};                      send_frame(fb, 10, 0); check_state("b2b");
    fb = '{8'h70};                             send_frame(fb, 1, 0);
    fb = '{8'h11, 8'hC3};                      send_frame(fb, 10, 0); check_state("b2b_err");

    // reset mid-frame after two data bytes
    cs = 1'b0;
    repeat (4) @(negedge clk);
    push_byte(8'h10, 1);
    push_byte(8'h11, 2);
    push_byte(8'h22, 1);
    reset = 1'b0;
    #1;
    model_defaults();
    check_state("rst_mid");
    chk("rst_mid.update", {31'h0, update}, 32'h0);
    cs = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    fb = '{8'h10, 8'hAA};                      send_frame(fb, 10, 6); check_state("post_rst");

    // randomized frames
    for (int it = 0; it < 40; it++) begin
      r = int'($urandom_range(0, 9));
      if (r < 5)      hdr = {4'h1, 4'($urandom_range(0, 6))};
      else if (r < 7) hdr = {4'h3, 4'($urandom)};
      else            hdr = 8'($urandom);
      fb = {};
      n = int'($urandom_range(0, 8));
      if (n > 0) fb.push_back(hdr);
      for (int k = 1; k < n; k++) fb.push_back(8'($urandom));
      send_frame(fb, 10, 0);
      check_state($sformatf("rnd%0d", it));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
